qos_wrr_scheduler: RTL

//  Table-driven weighted round-robin read scheduler for the four VC FIFOs in the QoS path.
//  - Walks a programmable arbitration table and drives the one-hot FIFO read enables and
//    the output mux selector.
//  - Sits between the fifo8 VC queues and the output mux; honours downstream pause.

---
 rtl/qos_wrr_scheduler_pkg.sv | 29 ++
 rtl/qos_wrr_scheduler_if.sv | 32 +++
 rtl/qos_wrr_scheduler_arb_table.sv | 27 ++
 rtl/qos_wrr_scheduler.sv | 124 ++++++++++++
 4 files changed

// File: rtl/qos_wrr_scheduler_pkg.sv
// Shared types and constants for the QoS weighted round-robin read scheduler.
// Holds the FSM encoding, table entry layout and the reset-time table contents.
package qos_wrr_scheduler_pkg;
    localparam int QUEUE_QUANTITY = 4;
    localparam int TABLE_SIZE     = 8;
    localparam int MAX_WEIGHT     = 64;
    localparam int WW             = $clog2(MAX_WEIGHT) + 1;
    localparam int QW             = $clog2(QUEUE_QUANTITY);
    localparam int TW             = $clog2(TABLE_SIZE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SERVE = 2'd2
    } state_e;

    typedef struct packed {
        logic [QW-1:0] vc;
        logic [WW-1:0] weight;
    } entry_t;

    // Reset table: entry i serves VC (i mod QUEUE_QUANTITY) once per visit.
    function automatic entry_t default_entry(input int idx);
        entry_t e;
        e.vc     = QW'(idx % QUEUE_QUANTITY);
        e.weight = WW'(1);
        return e;
    endfunction
endpackage

// File: rtl/qos_wrr_scheduler_if.sv
// Scheduler-facing bundle: FIFO status, pause, table programming and read controls.
// Handshake: a FIFO word is popped on every cycle its vc_rd_en bit is high; data_valid follows one cycle later.
interface qos_wrr_scheduler_if;
    import qos_wrr_scheduler_pkg::*;

    logic                      enb;
    logic [QUEUE_QUANTITY-1:0] vc_empty;
    logic [QUEUE_QUANTITY-1:0] vc_almost_full;
    logic                      pause_in;
    logic                      cfg_wr;
    logic [TW-1:0]             cfg_addr;
    logic [QW-1:0]             cfg_vc;
    logic [WW-1:0]             cfg_weight;
    logic [QUEUE_QUANTITY-1:0] vc_rd_en;
    logic [QW-1:0]             selector;
    logic                      data_valid;
    logic                      idle;
    logic [TW-1:0]             cur_entry;
    state_e                    dbg_state;

    modport master (
        output enb, vc_empty, vc_almost_full, pause_in,
        output cfg_wr, cfg_addr, cfg_vc, cfg_weight,
        input  vc_rd_en, selector, data_valid, idle, cur_entry, dbg_state
    );

    modport slave (
        input  enb, vc_empty, vc_almost_full, pause_in,
        input  cfg_wr, cfg_addr, cfg_vc, cfg_weight,
        output vc_rd_en, selector, data_valid, idle, cur_entry, dbg_state
    );
endinterface

// File: rtl/qos_wrr_scheduler_arb_table.sv
// Arbitration table: TABLE_SIZE x {vc, weight} registers, one synchronous write, one async read.
// Reset has priority over a coincident write so the table always comes up as the default.
module qos_arb_table
    import qos_wrr_scheduler_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic [TW-1:0] wr_addr_i,
    input  entry_t        wr_data_i,
    input  logic [TW-1:0] rd_addr_i,
    output entry_t        rd_data_o
);
    entry_t entries_q [TABLE_SIZE];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < TABLE_SIZE; i++) begin
                entries_q[i] <= default_entry(i);
            end
        end else if (wr_en_i) begin
            entries_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = entries_q[rd_addr_i];
endmodule

// File: rtl/qos_wrr_scheduler.sv
// Weighted round-robin read scheduler for the VC FIFOs: walks the arbitration table,
// grants one urgent read per table entry to almost-full VCs, and honours downstream pause.
module qos_wrr_scheduler
    import qos_wrr_scheduler_pkg::*;
(
    input logic                clk,
    input logic                rst,
    qos_wrr_scheduler_if.slave bus
);
    localparam logic [QUEUE_QUANTITY-1:0] RD_ONE = 1;

    state_e        state_q, state_d;
    logic [TW-1:0] ptr_q, ptr_d;
    logic [WW-1:0] credit_q, credit_d;
    logic [QW-1:0] cur_vc_q, cur_vc_d;
    logic          urgent_q, urgent_d;
    logic [QW-1:0] sel_q;
    logic          dv_q;
    logic          rd;
    logic [QW-1:0] urgent_vc;
    entry_t        tbl_entry;
    entry_t        wr_entry;

    always_comb begin
        wr_entry.vc     = bus.cfg_vc;
        wr_entry.weight = (bus.cfg_weight > WW'(MAX_WEIGHT)) ? WW'(MAX_WEIGHT) : bus.cfg_weight;
    end

    qos_arb_table u_table (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (bus.cfg_wr),
        .wr_addr_i (bus.cfg_addr),
        .wr_data_i (wr_entry),
        .rd_addr_i (ptr_q),
        .rd_data_o (tbl_entry)
    );

    always_comb begin
        urgent_vc = '0;
        for (int i = QUEUE_QUANTITY - 1; i >= 0; i--) begin
            if (bus.vc_almost_full[i]) urgent_vc = QW'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        cur_vc_d = cur_vc_q;
        urgent_d = urgent_q;
        rd       = 1'b0;
        if (!bus.enb) begin
            state_d  = IDLE;
            credit_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!(&bus.vc_empty)) state_d = LOAD;
                end
                LOAD: begin
                    if (&bus.vc_empty) begin
                        state_d = IDLE;
                    end else if ((|bus.vc_almost_full) && !urgent_q) begin
                        cur_vc_d = urgent_vc;
                        credit_d = WW'(1);
                        urgent_d = 1'b1;
                        state_d  = SERVE;
                    end else if (tbl_entry.weight == '0) begin
                        ptr_d = ptr_q + TW'(1);
                    end else begin
                        cur_vc_d = tbl_entry.vc;
                        credit_d = tbl_entry.weight;
                        urgent_d = 1'b0;
                        state_d  = SERVE;
                    end
                end
                SERVE: begin
                    rd = !bus.vc_empty[cur_vc_q] && !bus.pause_in;
                    if (rd) begin
                        credit_d = credit_q - WW'(1);
                        if (credit_q == WW'(1)) begin
                            state_d = LOAD;
                            // An urgent grant is an interjection; the table position stays put.
                            if (!urgent_q) ptr_d = ptr_q + TW'(1);
                        end
                    end else if (bus.vc_empty[cur_vc_q] && !bus.pause_in) begin
                        credit_d = '0;
                        ptr_d    = ptr_q + TW'(1);
                        state_d  = LOAD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            credit_q <= '0;
            cur_vc_q <= '0;
            urgent_q <= 1'b0;
            sel_q    <= '0;
            dv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            cur_vc_q <= cur_vc_d;
            urgent_q <= urgent_d;
            sel_q    <= cur_vc_q;
            dv_q     <= rd;
        end
    end

    assign bus.vc_rd_en   = rd ? (RD_ONE << cur_vc_q) : '0;
    assign bus.selector   = sel_q;
    assign bus.data_valid = dv_q;
    assign bus.idle       = (state_q == IDLE) && !dv_q;
    assign bus.cur_entry  = ptr_q;
    assign bus.dbg_state  = state_q;
endmodule
